onchip_mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the single-port 32-bit on-chip RAM (Avalon-MM slave, 14-bit word address, 10000 words, read latency 1) between master 0 (CPU data port) and master 1 (DMA/streaming engine).
- Issues at most one access per cycle to the RAM and returns read data to the issuing master with a 1-cycle readdatavalid pipeline.
- Blocks out-of-range addresses (>= DEPTH).

---
 rtl/onchip_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with a 1-cycle read return.
// Optional saturating error counter enabled by defining ONCHIP_MEM_ARB_ERR_CNT_EN.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 10000,
  parameter int ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]  err_count,
`endif
  output logic                  range_err
);

  localparam int BE_W = DATA_W / 8;
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              req0, req1, gnt0, gnt1, g_any;
  logic              g_read, g_write, in_range, illegal, oob_acc;
  logic [ADDR_W-1:0] g_addr;
  logic [BE_W-1:0]   g_be;
  logic [DATA_W-1:0] g_wdata;

  logic last_q, last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic rd_oob_q, rd_oob_d;
  logic range_err_q, range_err_d;

  // Round-robin grant: on contention the master that was not served last wins.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
    g_any = gnt0 | gnt1;
  end

  // Mux of the granted master; everything is zero when nobody is granted.
  always_comb begin
    g_addr  = '0;
    g_be    = '0;
    g_wdata = '0;
    g_read  = 1'b0;
    g_write = 1'b0;
    if (gnt1) begin
      g_addr  = m1_address;
      g_be    = m1_byteenable;
      g_wdata = m1_writedata;
      g_read  = m1_read;
      g_write = m1_write;
    end else if (gnt0) begin
      g_addr  = m0_address;
      g_be    = m0_byteenable;
      g_wdata = m0_writedata;
      g_read  = m0_read;
      g_write = m0_write;
    end else begin
      g_addr  = '0;
    end
    in_range = ({1'b0, g_addr} < DEPTH_L);
    illegal  = g_read & g_write;
    oob_acc  = g_any & ~in_range;
  end

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;
  assign mem_address    = g_addr;
  assign mem_byteenable = g_be;
  assign mem_writedata  = g_wdata;
  assign mem_chipselect = g_any & in_range;
  assign mem_write      = g_write & in_range;
  assign mem_clken      = 1'b1;

  // Next state for the priority pointer, read pipeline and sticky error flag.
  always_comb begin
    last_d      = g_any ? gnt1 : last_q;
    rd_pend_d   = g_read & ~g_write;
    rd_owner_d  = gnt1;
    rd_oob_d    = ~in_range;
    range_err_d = range_err_q | oob_acc | illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      rd_oob_q    <= rd_oob_d;
      range_err_q <= range_err_d;
    end
  end

  // Return path: out-of-range reads come back as zero with normal timing.
  always_comb begin
    m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = rd_pend_q & rd_owner_q;
    m0_readdata      = (m0_readdatavalid && !rd_oob_q) ? mem_readdata : '0;
    m1_readdata      = (m1_readdatavalid && !rd_oob_q) ? mem_readdata : '0;
  end

  assign range_err = range_err_q;

`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Saturating count of accepted out-of-range or illegal accesses.
  always_comb begin
    err_count_d = err_count_q;
    if ((oob_acc || illegal) && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  localparam int unused_err_cnt_w = ERR_CNT_W;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM behind it.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken, range_err;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  logic [31:0] ram [0:16383];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
    .err_count(err_count),
`endif
    .range_err(range_err)
  );

  // RAM model: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 14'h0; m0_byteenable = 4'h0; m0_writedata = 32'h0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 14'h0; m1_byteenable = 4'h0; m1_writedata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] a0, a1, exp_addr;
    logic        exp1;
    int          v0, v1;

    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    for (int i = 0; i < 6; i++) ram[14'h20 + i] = 32'hA000_0000 + 32'(14'h20 + i);
    ram[14'h30]   = 32'h1122_3344;
    ram[14'h2710] = 32'hCAFE_F00D;
    mem_readdata  = 32'h0;
    idle();
    reset = 1'b1;
    tick();

    // Reset state; grant stays combinational with last = 0.
    m0_read = 1'b1; m1_read = 1'b1;
    #1;
    check_val("rst_wait0", 32'(m0_waitrequest), 32'd1);
    check_val("rst_wait1", 32'(m1_waitrequest), 32'd0);
    check_val("rst_clken", 32'(mem_clken), 32'd1);
    check_val("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    check_val("rst_rerr", 32'(range_err), 32'd0);
    tick();
    idle();
    tick();
    reset = 1'b0;

    // Basic write then read by m0.
    m0_write = 1'b1; m0_address = 14'h0010; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
    #1;
    check_val("w_wait0", 32'(m0_waitrequest), 32'd0);
    check_val("w_cs", 32'(mem_chipselect), 32'd1);
    check_val("w_we", 32'(mem_write), 32'd1);
    check_val("w_addr", 32'(mem_address), 32'h10);
    tick();
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    check_val("r_wait0", 32'(m0_waitrequest), 32'd0);
    check_val("r_we", 32'(mem_write), 32'd0);
    tick();
    idle();
    check_val("r_rdv0", 32'(m0_readdatavalid), 32'd1);
    check_val("r_data0", m0_readdata, 32'hDEAD_BEEF);
    check_val("r_rdv1", 32'(m1_readdatavalid), 32'd0);
    check_val("r_data1", m1_readdata, 32'h0);
    tick();
    check_val("r_rdv0_once", 32'(m0_readdatavalid), 32'd0);

    // Continuous contention from reset: m1, m0, m1, m0, m1, m0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0 = 14'h20; a1 = 14'h23; v0 = 0; v1 = 0;
    for (int k = 0; k < 6; k++) begin
      m0_read = 1'b1; m0_address = a0;
      m1_read = 1'b1; m1_address = a1;
      exp1 = (k % 2 == 0);
      exp_addr = exp1 ? a1 : a0;
      #1;
      check_val($sformatf("rr_wait0_%0d", k), 32'(m0_waitrequest), 32'(exp1));
      check_val($sformatf("rr_wait1_%0d", k), 32'(m1_waitrequest), 32'(!exp1));
      tick();
      v0 += int'(m0_readdatavalid);
      v1 += int'(m1_readdatavalid);
      check_val($sformatf("rr_rdv1_%0d", k), 32'(m1_readdatavalid), 32'(exp1));
      check_val($sformatf("rr_rdv0_%0d", k), 32'(m0_readdatavalid), 32'(!exp1));
      check_val($sformatf("rr_data_%0d", k), exp1 ? m1_readdata : m0_readdata,
                32'hA000_0000 + 32'(exp_addr));
      if (exp1) a1 = a1 + 14'd1; else a0 = a0 + 14'd1;
    end
    idle();
    tick();
    check_val("rr_cnt0", 32'(v0), 32'd3);
    check_val("rr_cnt1", 32'(v1), 32'd3);

    // Byte-lane write from m1.
    m1_write = 1'b1; m1_address = 14'h30; m1_byteenable = 4'b0001; m1_writedata = 32'h0000_00AA;
    tick();
    m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
    tick();
    idle();
    check_val("be_rdv1", 32'(m1_readdatavalid), 32'd1);
    check_val("be_data1", m1_readdata, 32'h1122_33AA);

    // Out-of-range write and read at DEPTH.
    m0_write = 1'b1; m0_address = 14'h2710; m0_byteenable = 4'hF; m0_writedata = 32'h1234_5678;
    #1;
    check_val("oob_w_wait", 32'(m0_waitrequest), 32'd0);
    check_val("oob_w_cs", 32'(mem_chipselect), 32'd0);
    check_val("oob_w_we", 32'(mem_write), 32'd0);
    tick();
    check_val("oob_rerr", 32'(range_err), 32'd1);
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    check_val("oob_r_cs", 32'(mem_chipselect), 32'd0);
    tick();
    idle();
    check_val("oob_rdv0", 32'(m0_readdatavalid), 32'd1);
    check_val("oob_data0", m0_readdata, 32'h0);
    check_val("oob_ram", ram[14'h2710], 32'hCAFE_F00D);
`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
    check_val("oob_errcnt", 32'(err_count), 32'd2);
`endif
    tick();
    check_val("oob_sticky", 32'(range_err), 32'd1);

    // m1 read accepted (last -> 1) while reset is sampled at the same edge.
    m1_read = 1'b1; m1_address = 14'h10;
    reset = 1'b1;
    #1;
    check_val("rst_mid_wait1", 32'(m1_waitrequest), 32'd0);
    tick();
    reset = 1'b0;
    check_val("rst_mid_rdv1", 32'(m1_readdatavalid), 32'd0);
    check_val("rst_mid_rerr", 32'(range_err), 32'd0);
    m0_read = 1'b1; m0_address = 14'h10;
    #1;
    check_val("rst_mid_last", 32'(m0_waitrequest), 32'd1);
    idle();
    tick();
    tick();

    // Illegal read+write from m1: performed as a write only.
    m1_read = 1'b1; m1_write = 1'b1; m1_address = 14'h0005; m1_byteenable = 4'hF;
    m1_writedata = 32'h0000_0055;
    #1;
    check_val("ill_wait1", 32'(m1_waitrequest), 32'd0);
    check_val("ill_we", 32'(mem_write), 32'd1);
    tick();
    idle();
    check_val("ill_rdv1", 32'(m1_readdatavalid), 32'd0);
    check_val("ill_rerr", 32'(range_err), 32'd1);
    check_val("ill_ram", ram[14'h0005], 32'h0000_0055);
`ifdef ONCHIP_MEM_ARB_ERR_CNT_EN
    check_val("ill_errcnt", 32'(err_count), 32'd1);
`endif
    tick();
    check_val("ill_rdv1_late", 32'(m1_readdatavalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
